// File: rtl/zjh_code_conv_seq.sv
// Sequential binary<->BCD converter: one shift-and-correct step per clock,
// with a valid/ready handshake on both the request side and the result side.
module zjh_code_conv_seq #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mode,
    input  logic [BIN_W-1:0]      din_bin,
    input  logic [4*DIGITS-1:0]   din_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      dout_bin,
    output logic [4*DIGITS-1:0]   dout_bcd,
    output logic                  err
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t              state;
    logic                mode_q;
    logic [BCD_W-1:0]    bcd_q;
    logic [BIN_W-1:0]    bin_q;
    logic [CNT_W-1:0]    cnt;

    logic [BCD_W-1:0]    bcd_adj_c;
    logic [BCD_W-1:0]    bcd_nxt_c;
    logic [BIN_W-1:0]    bin_nxt_c;
    logic                carry_c;
    logic                bad_digit_c;

    // Flag any BCD input nibble above 9
    always_comb begin
        bad_digit_c = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (din_bcd[4*i +: 4] > 4'd9) bad_digit_c = 1'b1;
        end
    end

    // One dabble step: correct-then-shift-left (bin->bcd) or shift-right-then-correct (bcd->bin)
    always_comb begin
        bcd_adj_c = bcd_q;
        bcd_nxt_c = bcd_q;
        bin_nxt_c = bin_q;
        carry_c   = 1'b0;
        if (!mode_q) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
            {carry_c, bcd_nxt_c, bin_nxt_c} = {bcd_adj_c, bin_q, 1'b0};
        end else begin
            {bcd_adj_c, bin_nxt_c} = {1'b0, bcd_q, bin_q[BIN_W-1:1]};
            for (int i = 0; i < DIGITS; i++) begin
                if (bcd_adj_c[4*i +: 4] >= 4'd8) bcd_nxt_c[4*i +: 4] = bcd_adj_c[4*i +: 4] - 4'd3;
                else                             bcd_nxt_c[4*i +: 4] = bcd_adj_c[4*i +: 4];
            end
        end
    end

    // Control FSM, working registers and registered result/handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            dout_bin  <= '0;
            dout_bcd  <= '0;
            err       <= 1'b0;
            cnt       <= '0;
            mode_q    <= 1'b0;
            bcd_q     <= '0;
            bin_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mode_q   <= mode;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        err      <= 1'b0;
                        state    <= CONV;
                        if (mode) begin
                            bcd_q <= din_bcd;
                            bin_q <= '0;
                            // Illegal digit: skip the iterations, finish on the next edge
                            if (bad_digit_c) begin
                                err <= 1'b1;
                                cnt <= CNT_LAST;
                            end
                        end else begin
                            bcd_q <= '0;
                            bin_q <= din_bin;
                        end
                    end
                end
                CONV: begin
                    if (cnt == CNT_LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        dout_bin  <= mode_q ? bin_q : '0;
                        dout_bcd  <= mode_q ? '0 : bcd_q;
                    end else begin
                        bcd_q <= bcd_nxt_c;
                        bin_q <= bin_nxt_c;
                        cnt   <= cnt + CNT_W'(1);
                        if (!mode_q && carry_c) err <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zjh_code_conv_seq.sv
// Self-checking bench for zjh_code_conv_seq using an arithmetic reference model.
module tb_zjh_code_conv_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [13:0] din_bin;
    logic [15:0] din_bcd;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] dout_bin;
    logic [15:0] dout_bcd;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    zjh_code_conv_seq #(.DIGITS(4), .BIN_W(14)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .din_bin   (din_bin),
        .din_bcd   (din_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout_bin  (dout_bin),
        .dout_bcd  (dout_bcd),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: binary -> BCD by decimal arithmetic, overflow when >= 10**4
    task automatic ref_bin2bcd(input logic [13:0] b, output logic [15:0] bcd, output logic e);
        int r;
        r   = int'(b) % 10000;
        e   = (int'(b) >= 10000);
        bcd = '0;
        for (int i = 0; i < 4; i++) begin
            bcd[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
    endtask

    // Reference: BCD -> binary by digit weights, any nibble > 9 is illegal
    task automatic ref_bcd2bin(input logic [15:0] d, output logic [13:0] b, output logic e);
        int v;
        v = 0;
        e = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (d[4*i +: 4] > 4'd9) e = 1'b1;
            v = v * 10 + int'(d[4*i +: 4]);
        end
        b = e ? 14'd0 : 14'(v);
    endtask

    // One full transaction: accept, wait for result, hold for 'hold' cycles, consume
    task automatic do_conv(input logic m, input logic [13:0] b, input logic [15:0] d, input int hold);
        logic [15:0] e_bcd;
        logic [13:0] e_bin;
        logic        e_err;
        int          e_lat;
        int          lat;
        bit          seen;
        bit          busy_bad;
        bit          stable_bad;
        if (!m) begin
            ref_bin2bcd(b, e_bcd, e_err);
            e_bin = '0;
            e_lat = 15;
        end else begin
            ref_bcd2bin(d, e_bin, e_err);
            e_bcd = '0;
            e_lat = e_err ? 1 : 15;
        end
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        mode     = m;
        din_bin  = b;
        din_bcd  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        din_bin  = 14'($urandom);
        din_bcd  = 16'($urandom);
        mode     = 1'($urandom);
        lat      = 0;
        seen     = 1'b0;
        busy_bad = 1'b0;
        while (!seen && lat < 40) begin
            if (out_valid) seen = 1'b1;
            else begin
                if (in_ready) busy_bad = 1'b1;
                @(posedge clk);
                #1;
                lat++;
            end
        end
        chk("out_valid_seen", 32'(seen), 32'd1);
        chk("in_ready_busy", 32'(busy_bad), 32'd0);
        if (seen) begin
            chk("latency",  32'(lat),      32'(e_lat));
            chk("dout_bcd", 32'(dout_bcd), 32'(e_bcd));
            chk("dout_bin", 32'(dout_bin), 32'(e_bin));
            chk("err",      32'(err),      32'(e_err));
            chk("excl_rdy", 32'(in_ready), 32'd0);
            stable_bad = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                if (!out_valid || in_ready || dout_bcd !== e_bcd || dout_bin !== e_bin || err !== e_err)
                    stable_bad = 1'b1;
            end
            chk("hold_stable", 32'(stable_bad), 32'd0);
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk("consumed_valid", 32'(out_valid), 32'd0);
            chk("consumed_ready", 32'(in_ready),  32'd1);
        end
    endtask

    initial begin
        bit          leak;
        logic [15:0] rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        mode      = 1'b0;
        din_bin   = '0;
        din_bcd   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dout_bin",  32'(dout_bin),  32'd0);
        chk("rst_dout_bcd",  32'(dout_bcd),  32'd0);
        chk("rst_err",       32'(err),       32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        do_conv(1'b0, 14'd9999,  16'h0000, 0);
        do_conv(1'b1, 14'd0,     16'h1234, 0);
        do_conv(1'b1, 14'd0,     16'h0000, 0);
        do_conv(1'b0, 14'd12345, 16'h0000, 0);
        do_conv(1'b1, 14'd0,     16'h12A4, 0);
        do_conv(1'b0, 14'd0,     16'h0000, 0);
        do_conv(1'b0, 14'd10000, 16'h0000, 0);
        do_conv(1'b0, 14'd16383, 16'h0000, 0);
        do_conv(1'b1, 14'd0,     16'h9999, 0);
        do_conv(1'b1, 14'd0,     16'hF000, 0);

        // Stalled consumer, then back-to-back requests
        do_conv(1'b0, 14'd4821,  16'h0000, 5);
        do_conv(1'b1, 14'd0,     16'h0507, 0);
        do_conv(1'b0, 14'd42,    16'h0000, 0);

        // Reset in the middle of a conversion
        @(negedge clk);
        in_valid = 1'b1;
        mode     = 1'b0;
        din_bin  = 14'd1234;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_dout_bcd",  32'(dout_bcd),  32'd0);
        chk("midrst_dout_bin",  32'(dout_bin),  32'd0);
        chk("midrst_err",       32'(err),       32'd0);
        @(negedge clk);
        rst = 1'b0;
        leak = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || !in_ready) leak = 1'b1;
        end
        chk("midrst_no_result", 32'(leak), 32'd0);
        do_conv(1'b0, 14'd1234, 16'h0000, 0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(1, 0) == 0) begin
                do_conv(1'b0, 14'($urandom), 16'h0000, int'($urandom_range(3, 0)));
            end else begin
                rb = 16'($urandom);
                if ($urandom_range(3, 0) != 0) begin
                    for (int i = 0; i < 4; i++) rb[4*i +: 4] = 4'($urandom_range(9, 0));
                end
                do_conv(1'b1, 14'd0, rb, int'($urandom_range(3, 0)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
